agg_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one aggregator sender port between NUM_SRC narrow source FIFOs.
- Grants one source for exactly FETCH_WIDTH dequeues (one packed receiver word), then re-arbitrates. Each packed word therefore holds data from a single source.
- Sits between the per-source FIFOs (SyncFIFO read side) and aggregator's sender_data/sender_empty_n/sender_deq.

---
 rtl/agg_rr_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_agg_rr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agg_rr_arbiter.sv
// agg_rr_arbiter: shares one aggregator sender port among NUM_SRC source FIFOs.
// A granted source keeps the port for exactly FETCH_WIDTH accepted beats, so
// every packed receiver word holds data from a single source. The arbiter then
// spends one IDLE cycle re-arbitrating in round-robin order from last+1.
//
// Optional feature, enabled by defining ARB_PRIO0_EN:
//   Source 0 becomes high priority and gains the extra output port prio_hit.
//   Priority grants alternate with round-robin grants among sources
//   1..NUM_SRC-1, which gives the grant order 0,1,0,2,0,3 when every source
//   requests. Source 0 is granted back-to-back only when no other source is
//   waiting. A source-0 burst leaves the round-robin pointer unchanged.
//   With the macro undefined the block is a plain round-robin arbiter with no
//   prio_hit port.

module agg_rr_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int NUM_SRC     = 4,
  parameter int ID_WIDTH    = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_empty_n,
  output logic [NUM_SRC-1:0]            src_deq,
  output logic [DATA_WIDTH-1:0]         agg_data,
  output logic                          agg_empty_n,
  input  logic                          agg_deq,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          burst_done
`ifdef ARB_PRIO0_EN
  ,
  output logic                          prio_hit
`endif
);

  localparam int CNT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_WIDTH - 1);
  localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(NUM_SRC - 1);

`ifdef ARB_PRIO0_EN
  // Source 0 is served through the priority path, so round-robin skips it.
  localparam bit RR_SKIP0 = 1'b1;
`else
  localparam bit RR_SKIP0 = 1'b0;
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] last_q, last_d;

`ifdef ARB_PRIO0_EN
  logic prio_q, prio_d;            // current burst was a priority grant
  logic prev_prio_q, prev_prio_d;  // previous burst was a priority grant
  logic sel_prio;
`endif

  logic                  rr_found;
  logic [ID_WIDTH-1:0]   rr_id;
  logic                  sel_found;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_req;
  logic                  in_burst;
  logic                  accept;
  logic                  final_beat;

  // Round-robin search: the first requester at last+1, last+2, ... mod NUM_SRC.
  always_comb begin
    int                  idx;
    logic [ID_WIDTH-1:0] cand;
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    rr_found = 1'b0;
    rr_id    = '0;
    idx      = 0;
    cand     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx  = (int'(last_q) + k) % NUM_SRC;
      cand = ID_WIDTH'(idx);
      if (!rr_found && src_empty_n[cand] && ((cand != '0) || !RR_SKIP0)) begin
        rr_found = 1'b1;
        rr_id    = cand;
      end
    end
  end

  // Final selection for the next grant, with the optional source-0 priority.
  always_comb begin
`ifdef ARB_PRIO0_EN
    sel_prio  = src_empty_n[0] && (!prev_prio_q || !rr_found);
    sel_found = sel_prio || rr_found;
    sel_id    = sel_prio ? '0 : rr_id;
`else
    sel_found = rr_found;
    sel_id    = rr_id;
`endif
  end

  // Mux the data word and not-empty flag of the granted source.
  always_comb begin
    gnt_data = '0;
    gnt_req  = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant_id_q == ID_WIDTH'(s)) begin
        gnt_data = src_data[s*DATA_WIDTH +: DATA_WIDTH];
        gnt_req  = src_empty_n[s];
      end
    end
  end

  // Handshake decode. An agg_deq seen while the granted FIFO is empty is ignored.
  always_comb begin
    in_burst   = (state_q == S_BURST);
    accept     = in_burst && agg_deq && gnt_req;
    final_beat = accept && (cnt_q == CNT_LAST);
  end

  // Drive the aggregator side and the per-source dequeue strobes.
  always_comb begin
    agg_data    = in_burst ? gnt_data : '0;
    agg_empty_n = in_burst && gnt_req;
    grant_valid = in_burst;
    grant_id    = grant_id_q;
    burst_done  = final_beat;
    src_deq     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_deq[s] = accept && (grant_id_q == ID_WIDTH'(s));
    end
`ifdef ARB_PRIO0_EN
    prio_hit = prio_q;
`endif
  end

  // Next-state logic: grant in IDLE, then count FETCH_WIDTH accepted beats.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
`ifdef ARB_PRIO0_EN
    prio_d      = prio_q;
    prev_prio_d = prev_prio_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d    = S_BURST;
          grant_id_d = sel_id;
          cnt_d      = '0;
`ifdef ARB_PRIO0_EN
          prio_d     = sel_prio;
`endif
        end
      end
      S_BURST: begin
        if (final_beat) begin
          state_d = S_IDLE;
          cnt_d   = '0;
`ifdef ARB_PRIO0_EN
          // A priority burst leaves the round-robin pointer untouched.
          if (!prio_q) begin
            last_d = grant_id_q;
          end
          prev_prio_d = prio_q;
          prio_d      = 1'b0;
`else
          last_d = grant_id_q;
`endif
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; an asynchronous reset abandons any partial burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      state_q    <= S_IDLE;
      grant_id_q <= '0;
      cnt_q      <= '0;
      last_q     <= LAST_RST;
`ifdef ARB_PRIO0_EN
      prio_q      <= 1'b0;
      prev_prio_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
`ifdef ARB_PRIO0_EN
      prio_q      <= prio_d;
      prev_prio_q <= prev_prio_d;
`endif
    end
  end

endmodule

// File: tb/tb_agg_rr_arbiter.sv
// Testbench for agg_rr_arbiter: behavioural source FIFOs feed the DUT, and the
// stimulus pushes the expected beat sequence into a scoreboard. A negedge
// monitor pops and compares each beat as the aggregator accepts it.

module tb_agg_rr_arbiter;

  localparam int DW = 8;
  localparam int FW = 2;
  localparam int NS = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NS*DW-1:0]  src_data = '0;
  logic [NS-1:0]     src_empty_n = '0;
  logic [NS-1:0]     src_deq;
  logic [DW-1:0]     agg_data;
  logic              agg_empty_n;
  logic              agg_deq = 1'b0;
  logic              grant_valid;
  logic [IW-1:0]     grant_id;
  logic              burst_done;
`ifdef ARB_PRIO0_EN
  logic              prio_hit;
`endif

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
    logic          prio;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] fifo[NS][$];
  logic [NS-1:0] deq_s = '0;
  int            errors = 0;
  int            checks = 0;

  agg_rr_arbiter #(
    .DATA_WIDTH (DW),
    .FETCH_WIDTH(FW),
    .NUM_SRC    (NS),
    .ID_WIDTH   (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_data   (src_data),
    .src_empty_n(src_empty_n),
    .src_deq    (src_deq),
    .agg_data   (agg_data),
    .agg_empty_n(agg_empty_n),
    .agg_deq    (agg_deq),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .burst_done (burst_done)
`ifdef ARB_PRIO0_EN
    ,
    .prio_hit   (prio_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source FIFO model: capture dequeues at negedge, pop after the edge, then
  // present the new head word.
  always @(negedge clk) deq_s = src_deq;

  always @(posedge clk) begin
    #1;
    for (int s = 0; s < NS; s++) begin
      if (deq_s[s] && fifo[s].size() > 0) void'(fifo[s].pop_front());
    end
    deq_s = '0;
    #1;
    for (int s = 0; s < NS; s++) begin
      src_empty_n[s]          = (fifo[s].size() > 0);
      src_data[s*DW +: DW]    = (fifo[s].size() > 0) ? fifo[s][0] : '0;
    end
  end

  // Monitor: compare each accepted beat with the scoreboard head.
  always @(negedge clk) begin
    exp_t          e;
    logic [NS-1:0] exp_deq;
    if (rst_n) begin
      check("deq_onehot0", {31'd0, $onehot0(src_deq)}, 32'd1);
      if (agg_empty_n && agg_deq) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat at %0t",
                   grant_id, agg_data, $time);
        end else begin
          e = sb.pop_front();
          exp_deq = '0;
          exp_deq[e.id] = 1'b1;
          check("beat_id", {30'd0, grant_id}, {30'd0, e.id});
          check("beat_data", {24'd0, agg_data}, {24'd0, e.data});
          check("beat_done", {31'd0, burst_done}, {31'd0, e.last});
          check("beat_deq", {28'd0, src_deq}, {28'd0, exp_deq});
`ifdef ARB_PRIO0_EN
          check("beat_prio", {31'd0, prio_hit}, {31'd0, e.prio});
`endif
        end
      end else begin
        check("nobeat_deq", {28'd0, src_deq}, 32'd0);
        check("nobeat_done", {31'd0, burst_done}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [DW-1:0] d);
    fifo[s].push_back(d);
  endtask

  task automatic expect_beat(input int id, input logic [DW-1:0] d, input logic last,
                             input logic prio);
    exp_t e;
    e.id   = IW'(id);
    e.data = d;
    e.last = last;
    e.prio = prio;
    sb.push_back(e);
  endtask

  // Push two words to source s and the matching two-beat burst expectation.
  task automatic burst(input int s, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic prio);
    push(s, d0);
    push(s, d1);
    expect_beat(s, d0, 1'b0, prio);
    expect_beat(s, d1, 1'b1, prio);
  endtask

  task automatic clear_all();
    for (int s = 0; s < NS; s++) fifo[s].delete();
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() > 0 || grant_valid) && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, (n < budget)}, 32'd1);
    check("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[6];
    order = '{0, 1, 2, 3, 0, 1};

    // Reset values, observed while reset is still asserted.
    #2 rst_n = 1'b0;
    #1;
    check("rst_gv", {31'd0, grant_valid}, 32'd0);
    check("rst_gid", {30'd0, grant_id}, 32'd0);
    check("rst_deq", {28'd0, src_deq}, 32'd0);
    check("rst_empty_n", {31'd0, agg_empty_n}, 32'd0);
    check("rst_data", {24'd0, agg_data}, 32'd0);
    check("rst_done", {31'd0, burst_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single source: source 2 holds 10, 11.
    agg_deq = 1'b1;
    burst(2, 8'h10, 8'h11, 1'b0);
    check("t1_idle_gv", {31'd0, grant_valid}, 32'd0);
    tick();
    check("t1_gv", {31'd0, grant_valid}, 32'd1);
    check("t1_gid", {30'd0, grant_id}, 32'd2);
    wait_drain("t1_drain", 20);
    check("t1_end_gv", {31'd0, grant_valid}, 32'd0);
    check("t1_hold_gid", {30'd0, grant_id}, 32'd2);

`ifndef ARB_PRIO0_EN
    // All sources requesting: order 0,1,2,3,0,1, one IDLE cycle between bursts.
    do_reset();
    agg_deq = 1'b1;
    burst(0, 8'h00, 8'h01, 1'b0);
    burst(1, 8'h10, 8'h11, 1'b0);
    burst(2, 8'h20, 8'h21, 1'b0);
    burst(3, 8'h30, 8'h31, 1'b0);
    burst(0, 8'h02, 8'h03, 1'b0);
    burst(1, 8'h12, 8'h13, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("t2_gv", {31'd0, grant_valid}, {31'd0, (k % 3 != 0)});
      if (k % 3 != 0) check("t2_gid", {30'd0, grant_id}, order[(k - 1) / 3]);
    end
    wait_drain("t2_drain", 20);

    // Mid-burst empty on source 1, with agg_deq held high through the gap.
    do_reset();
    agg_deq = 1'b1;
    push(1, 8'hA0);
    expect_beat(1, 8'hA0, 1'b0, 1'b0);
    expect_beat(1, 8'hA1, 1'b1, 1'b0);
    tick();
    check("t3_gid", {30'd0, grant_id}, 32'd1);
    tick();
    // Other sources start requesting during the gap; they must wait.
    burst(3, 8'h3A, 8'h3B, 1'b0);
    burst(0, 8'h0A, 8'h0B, 1'b0);
    for (int g = 0; g < 3; g++) begin
      #2;
      check("t3_gap_gv", {31'd0, grant_valid}, 32'd1);
      check("t3_gap_gid", {30'd0, grant_id}, 32'd1);
      check("t3_gap_empty_n", {31'd0, agg_empty_n}, 32'd0);
      check("t3_gap_deq", {28'd0, src_deq}, 32'd0);
      tick();
    end
    push(1, 8'hA1);
    wait_drain("t3_drain", 30);

    // Reset during the first beat of a source-3 burst.
    do_reset();
    agg_deq = 1'b1;
    push(3, 8'h30);
    push(3, 8'h31);
    tick();
    check("t5_gid", {30'd0, grant_id}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_gv", {31'd0, grant_valid}, 32'd0);
    check("t5_rst_gid", {30'd0, grant_id}, 32'd0);
    check("t5_rst_deq", {28'd0, src_deq}, 32'd0);
    check("t5_rst_empty_n", {31'd0, agg_empty_n}, 32'd0);
    check("t5_rst_data", {24'd0, agg_data}, 32'd0);
    check("t5_rst_done", {31'd0, burst_done}, 32'd0);
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    burst(0, 8'h40, 8'h41, 1'b0);
    burst(1, 8'h50, 8'h51, 1'b0);
    burst(2, 8'h60, 8'h62, 1'b0);
    burst(3, 8'h70, 8'h73, 1'b0);
    tick();
    check("t5_first_gv", {31'd0, grant_valid}, 32'd1);
    check("t5_first_gid", {30'd0, grant_id}, 32'd0);
    wait_drain("t5_drain", 30);
`else
    // Source 0 priority alternating with round-robin: 0,1,0,2,0,3.
    do_reset();
    agg_deq = 1'b1;
    burst(0, 8'h00, 8'h01, 1'b1);
    burst(1, 8'h10, 8'h11, 1'b0);
    burst(0, 8'h02, 8'h03, 1'b1);
    burst(2, 8'h20, 8'h21, 1'b0);
    burst(0, 8'h04, 8'h05, 1'b1);
    burst(3, 8'h30, 8'h31, 1'b0);
    tick();
    check("p_first_gid", {30'd0, grant_id}, 32'd0);
    check("p_first_hit", {31'd0, prio_hit}, 32'd1);
    wait_drain("p_drain", 40);
    check("p_idle_hit", {31'd0, prio_hit}, 32'd0);
`endif

    agg_deq = 1'b0;
    repeat (2) tick();
    check("final_sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
